// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: memory-style names, the style-select rule and a clog2 helper.
package fifo_pkg;

  localparam string MEM_STYLE_BLOCK = "block";
  localparam string MEM_STYLE_REGS  = "registers";

  // Capacities above the threshold go to block RAM; small FIFOs stay in registers.
  function automatic bit use_block_ram(input int data_width, input int depth, input int threshold);
    return (data_width * depth) > threshold;
  endfunction

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/fifo_almost_full_if.sv
// Stream channel between a producer/consumer (master) and the FIFO (slave).
interface fifo_almost_full_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  if_full_n;
  logic                  if_write_ce;
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_empty_n;
  logic                  if_read_ce;
  logic                  if_read;
  logic [DATA_WIDTH-1:0] if_dout;
  logic                  if_error;

  modport master (
    input  if_full_n, if_empty_n, if_dout, if_error,
    output if_write_ce, if_write, if_din, if_read_ce, if_read
  );

  modport slave (
    output if_full_n, if_empty_n, if_dout, if_error,
    input  if_write_ce, if_write, if_din, if_read_ce, if_read
  );
endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port FIFO storage: one write port, one registered read port with enable.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int    DATA_WIDTH = 32,
  parameter int    DEPTH      = 32,
  parameter int    ADDR_WIDTH = clog2(DEPTH),
  parameter string MEM_STYLE  = MEM_STYLE_BLOCK
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_rd_data;

  // NOTE: storage has no reset so it can map onto RAM primitives; the FIFO
  // pointers and counter are what make stale contents invisible after reset.
  generate
    if (MEM_STYLE == MEM_STYLE_BLOCK) begin : g_block
      (* ram_style = "block" *) logic [DATA_WIDTH-1:0] r_mem [DEPTH];
      always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
        if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
      end
    end else begin : g_regs
      // Same registered read as the RAM branch so latency does not depend on style.
      (* ram_style = "registers" *) logic [DATA_WIDTH-1:0] r_mem [DEPTH];
      always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
        if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
      end
    end
  endgenerate

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_almost_full.sv
// FWFT stream FIFO with early full_n deassertion (grace period) for relayed links.
// Define FIFO_ERROR_CHECK_EN to build the sticky misuse flag on if_error.
module fifo_almost_full
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int DEPTH        = 32,
  parameter int GRACE_PERIOD = 0,
  parameter int THRESHOLD    = 4096
) (
  input logic               clk,
  input logic               reset,
  fifo_almost_full_if.slave s_if
);

  localparam string MEM_STYLE =
    use_block_ram(DATA_WIDTH, DEPTH, THRESHOLD) ? MEM_STYLE_BLOCK : MEM_STYLE_REGS;
  localparam int                    CW          = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]         L_DEPTH     = CW'(DEPTH);
  localparam logic [CW-1:0]         L_FULL_MARK = CW'(DEPTH - GRACE_PERIOD);
  localparam logic [ADDR_WIDTH-1:0] L_LAST      = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] L_ONE       = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_q_valid;
  logic                  r_dout_valid;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_full_n;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_mem_has_data;
  logic                  w_load_out;
  logic                  w_mem_rd;
  logic [CW-1:0]         w_staged;
  logic [CW-1:0]         w_count_next;
  logic [DATA_WIDTH-1:0] w_q;

  assign w_push = s_if.if_write & s_if.if_write_ce & (r_count < L_DEPTH);
  assign w_pop  = s_if.if_read & s_if.if_read_ce & r_dout_valid;

  // r_count spans memory, the read-data register and the output register.
  assign w_staged       = CW'(r_q_valid) + CW'(r_dout_valid);
  assign w_mem_has_data = r_count > w_staged;
  assign w_load_out     = s_if.if_read_ce & r_q_valid & (~r_dout_valid | w_pop);
  assign w_mem_rd       = s_if.if_read_ce & w_mem_has_data & (~r_q_valid | w_load_out);
  assign w_count_next   = r_count + CW'(w_push) - CW'(w_pop);

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_STYLE  (MEM_STYLE)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (s_if.if_din),
    .i_rd_en   (w_mem_rd),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_q)
  );

  // NOTE: non-blocking assignments make every register here sample pre-edge
  // values, so statement order inside the block does not matter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_q_valid    <= 1'b0;
      r_dout_valid <= 1'b0;
      r_dout       <= '0;
      r_full_n     <= 1'b0;
    end else begin
      if (w_push)   r_wr_ptr <= (r_wr_ptr == L_LAST) ? '0 : r_wr_ptr + L_ONE;
      if (w_mem_rd) r_rd_ptr <= (r_rd_ptr == L_LAST) ? '0 : r_rd_ptr + L_ONE;
      r_count  <= w_count_next;
      r_full_n <= w_count_next < L_FULL_MARK;

      if (w_mem_rd)        r_q_valid <= 1'b1;
      else if (w_load_out) r_q_valid <= 1'b0;

      if (w_load_out) begin
        r_dout       <= w_q;
        r_dout_valid <= 1'b1;
      end else if (w_pop) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign s_if.if_full_n  = r_full_n;
  assign s_if.if_empty_n = r_dout_valid;
  assign s_if.if_dout    = r_dout;

`ifdef FIFO_ERROR_CHECK_EN
  logic r_error;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_error <= 1'b0;
    end else if ((s_if.if_write & s_if.if_write_ce & (r_count == L_DEPTH)) |
                 (s_if.if_read & s_if.if_read_ce & ~r_dout_valid)) begin
      r_error <= 1'b1;
    end
  end

  assign s_if.if_error = r_error;
`else
  assign s_if.if_error = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_almost_full.sv
// Scoreboard bench: DUT a (DEPTH=4, GRACE=2, block RAM), DUT b (DEPTH=5, registers).
module tb_fifo_almost_full;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

`ifdef FIFO_ERROR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  fifo_almost_full_if #(.DATA_WIDTH(32)) a_if ();
  fifo_almost_full_if #(.DATA_WIDTH(32)) b_if ();

  fifo_almost_full #(
    .DATA_WIDTH(32), .ADDR_WIDTH(2), .DEPTH(4), .GRACE_PERIOD(2), .THRESHOLD(0)
  ) u_dut_a (
    .clk(clk), .reset(reset), .s_if(a_if.slave)
  );

  fifo_almost_full #(
    .DATA_WIDTH(32), .ADDR_WIDTH(3), .DEPTH(5), .GRACE_PERIOD(0), .THRESHOLD(1 << 20)
  ) u_dut_b (
    .clk(clk), .reset(reset), .s_if(b_if.slave)
  );

  int total = 0;
  int bad   = 0;
  int recv_b = 0;
  logic [31:0] exp_a [$];
  logic [31:0] exp_b [$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input bit wr, input logic [31:0] d, input bit rd);
    a_if.if_write = wr;
    a_if.if_din   = d;
    a_if.if_read  = rd;
  endtask

  // Monitors: compare every word the DUT hands over against the scoreboard.
  always @(negedge clk) begin
    if (!reset && a_if.if_read && a_if.if_read_ce && a_if.if_empty_n) begin
      if (exp_a.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_pop_extra: got 0x%0h with no word expected", a_if.if_dout);
      end else begin
        check("a_pop_data", a_if.if_dout, exp_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && b_if.if_read && b_if.if_read_ce && b_if.if_empty_n) begin
      recv_b++;
      if (exp_b.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_pop_extra: got 0x%0h with no word expected", b_if.if_dout);
      end else begin
        check("b_pop_data", b_if.if_dout, exp_b.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] d;
    bit          w;
    bit          wce;
    int          sent;
    int          cyc;

    reset = 1'b1;
    a_if.if_write_ce = 1'b1; a_if.if_read_ce = 1'b1;
    a_drive(1'b0, '0, 1'b0);
    b_if.if_write_ce = 1'b1; b_if.if_read_ce = 1'b1;
    b_if.if_write = 1'b0; b_if.if_read = 1'b0; b_if.if_din = '0;
    repeat (2) tick();

    check("a_rst_full_n", a_if.if_full_n, 0);
    check("a_rst_empty_n", a_if.if_empty_n, 0);
    check("a_rst_dout", a_if.if_dout, 0);
    check("a_rst_error", a_if.if_error, 0);
    check("b_rst_full_n", b_if.if_full_n, 0);
    reset = 1'b0;
    tick();
    check("a_full_n_rise", a_if.if_full_n, 1);
    check("b_full_n_rise", b_if.if_full_n, 1);

    // Grace period: DEPTH=4, GRACE=2, full_n falls at count 2; writes 3,4 still land.
    a_drive(1'b1, 32'hA, 1'b0); exp_a.push_back(32'hA); tick();
    check("a_full_n_w1", a_if.if_full_n, 1);
    a_drive(1'b1, 32'hB, 1'b0); exp_a.push_back(32'hB); tick();
    check("a_full_n_w2", a_if.if_full_n, 0);
    a_drive(1'b1, 32'hC, 1'b0); exp_a.push_back(32'hC); tick();
    a_drive(1'b1, 32'hD, 1'b0); exp_a.push_back(32'hD); tick();
    check("a_full_n_w4", a_if.if_full_n, 0);
    a_drive(1'b1, 32'hE, 1'b0); tick();
    check("a_error_full_write", a_if.if_error, ERR_EN);
    a_drive(1'b0, '0, 1'b0); tick();
    check("a_head_A", a_if.if_dout, 32'hA);
    a_drive(1'b0, '0, 1'b1);
    repeat (2) tick();
    check("a_full_n_cnt2", a_if.if_full_n, 0);
    tick();
    check("a_full_n_cnt1", a_if.if_full_n, 1);
    tick();
    a_drive(1'b0, '0, 1'b0);
    check("a_empty_after_4", a_if.if_empty_n, 0);
    check("a_sb_drained_1", exp_a.size(), 0);

    // First-word latency into an empty FIFO, block-RAM style.
    a_drive(1'b1, 32'hF, 1'b0); exp_a.push_back(32'hF); tick();
    a_drive(1'b0, '0, 1'b0);
    check("a_lat_k", a_if.if_empty_n, 0);
    tick();
    check("a_lat_k1", a_if.if_empty_n, 0);
    tick();
    check("a_lat_k2_valid", a_if.if_empty_n, 1);
    check("a_lat_k2_dout", a_if.if_dout, 32'hF);
    a_drive(1'b0, '0, 1'b1); tick();
    a_drive(1'b0, '0, 1'b0);

    // Simultaneous read and write at count=1.
    a_drive(1'b1, 32'h16, 1'b0); exp_a.push_back(32'h16); tick();
    a_drive(1'b0, '0, 1'b0); repeat (2) tick();
    check("a_rw1_head", a_if.if_dout, 32'h16);
    a_drive(1'b1, 32'h17, 1'b1); exp_a.push_back(32'h17); tick();
    check("a_rw1_full_n", a_if.if_full_n, 1);
    a_drive(1'b1, 32'h18, 1'b0); exp_a.push_back(32'h18); tick();
    check("a_rw1_count2", a_if.if_full_n, 0);
    a_drive(1'b0, '0, 1'b0); repeat (2) tick();
    a_drive(1'b0, '0, 1'b1); repeat (2) tick();
    a_drive(1'b0, '0, 1'b0);
    check("a_rw1_empty", a_if.if_empty_n, 0);
    check("a_sb_drained_2", exp_a.size(), 0);

    // Simultaneous read and write at count=DEPTH: the write is dropped.
    a_drive(1'b1, 32'h21, 1'b0); exp_a.push_back(32'h21); tick();
    a_drive(1'b1, 32'h22, 1'b0); exp_a.push_back(32'h22); tick();
    a_drive(1'b1, 32'h23, 1'b0); exp_a.push_back(32'h23); tick();
    a_drive(1'b1, 32'h24, 1'b0); exp_a.push_back(32'h24); tick();
    a_drive(1'b0, '0, 1'b0); repeat (2) tick();
    a_drive(1'b1, 32'h25, 1'b1); tick();
    check("a_rwfull_full_n", a_if.if_full_n, 0);
    check("a_rwfull_error", a_if.if_error, ERR_EN);
    a_drive(1'b0, '0, 1'b1); repeat (3) tick();
    a_drive(1'b0, '0, 1'b0); repeat (3) tick();
    check("a_rwfull_dropped", a_if.if_empty_n, 0);
    check("a_sb_drained_3", exp_a.size(), 0);

    // Write enable low: request ignored.
    a_if.if_write_ce = 1'b0;
    a_drive(1'b1, 32'h30, 1'b0); repeat (3) tick();
    a_drive(1'b0, '0, 1'b0);
    a_if.if_write_ce = 1'b1;
    check("a_wce_low_ignored", a_if.if_empty_n, 0);

    // Reset with 3 words stored discards them.
    a_drive(1'b1, 32'h41, 1'b0); exp_a.push_back(32'h41); tick();
    a_drive(1'b1, 32'h42, 1'b0); exp_a.push_back(32'h42); tick();
    a_drive(1'b1, 32'h43, 1'b0); exp_a.push_back(32'h43); tick();
    a_drive(1'b0, '0, 1'b0); repeat (2) tick();
    check("a_pre_reset_valid", a_if.if_empty_n, 1);
    reset = 1'b1; tick();
    exp_a.delete();
    check("a_mid_rst_empty_n", a_if.if_empty_n, 0);
    check("a_mid_rst_full_n", a_if.if_full_n, 0);
    check("a_mid_rst_dout", a_if.if_dout, 0);
    reset = 1'b0; tick();
    check("a_mid_rst_full_n_rise", a_if.if_full_n, 1);
    repeat (3) tick();
    check("a_mid_rst_discard", a_if.if_empty_n, 0);

    // Read on an empty FIFO.
    a_drive(1'b0, '0, 1'b1); tick();
    a_drive(1'b0, '0, 1'b0);
    check("a_err_empty_read", a_if.if_error, ERR_EN);
    repeat (3) tick();
    check("a_err_held", a_if.if_error, ERR_EN);
    reset = 1'b1; tick();
    reset = 1'b0;
    check("a_err_cleared", a_if.if_error, 0);
    tick();

    // First-word latency, register style.
    b_if.if_write = 1'b1; b_if.if_din = 32'hB5; exp_b.push_back(32'hB5); tick();
    b_if.if_write = 1'b0;
    check("b_lat_k", b_if.if_empty_n, 0);
    tick();
    check("b_lat_k1", b_if.if_empty_n, 0);
    tick();
    check("b_lat_k2_valid", b_if.if_empty_n, 1);
    check("b_lat_k2_dout", b_if.if_dout, 32'hB5);
    b_if.if_read = 1'b1; tick();
    b_if.if_read = 1'b0;
    recv_b = 0;

    // DEPTH=5: 20 words with random stalls on both sides.
    sent = 0;
    cyc  = 0;
    while ((sent < 20 || recv_b < 20) && cyc < 2000) begin
      d   = 32'hB000_0000 + 32'(sent);
      w   = (sent < 20) && ($urandom_range(0, 3) != 0);
      wce = $urandom_range(0, 7) != 0;
      b_if.if_write    = w;
      b_if.if_write_ce = wce;
      b_if.if_din      = d;
      b_if.if_read     = $urandom_range(0, 2) != 0;
      b_if.if_read_ce  = $urandom_range(0, 7) != 0;
      if (w && wce && b_if.if_full_n) begin
        exp_b.push_back(d);
        sent++;
      end
      tick();
      cyc++;
    end
    b_if.if_write = 1'b0; b_if.if_read = 1'b0;
    b_if.if_write_ce = 1'b1; b_if.if_read_ce = 1'b1;
    check("b_stream_sent", sent, 20);
    check("b_stream_recv", recv_b, 20);
    check("b_sb_drained", exp_b.size(), 0);
    repeat (2) tick();
    check("b_stream_empty", b_if.if_empty_n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_almost_full.md
# fifo_almost_full

First-word fall-through FIFO, next generation of the team's stream FIFO. Adds a programmable grace period: `if_full_n` deasserts early so producers behind pipelined (relay) stream links can keep writing for up to GRACE_PERIOD more words after it falls. Supports non-power-of-two depths and selects block-RAM or register storage from total capacity. Sits on every inter-task stream channel, including channels crossing floorplan slots.

## Interface
- DATA_WIDTH, 32, word width in bits
- ADDR_WIDTH, 5, pointer width; DEPTH ≤ 2^ADDR_WIDTH
- DEPTH, 32, capacity in words, any value ≥ 2
- GRACE_PERIOD, 0, words accepted after `if_full_n` falls; 0 ≤ GRACE_PERIOD < DEPTH
- THRESHOLD, 4096, DATA_WIDTH*DEPTH above this selects block RAM, otherwise registers
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- if_full_n  out  1  registered; low when occupancy ≥ DEPTH−GRACE_PERIOD
- if_write_ce  in  1  write clock enable
- if_write  in  1  write request
- if_din  in  DATA_WIDTH  write data
- if_empty_n  out  1  registered; high when `if_dout` holds a valid head word
- if_read_ce  in  1  read clock enable
- if_read  in  1  read/pop request
- if_dout  out  DATA_WIDTH  head word (FWFT)
- if_error  out  1  sticky misuse flag (see Configuration)

## Operation
- Occupancy counter `count` (ADDR_WIDTH+1 bits) covers every stored word, including the output stage.
- Write accepted iff if_write & if_write_ce & (count < DEPTH). `if_full_n` is not the acceptance condition. Writes while `if_full_n`=0 are legal while count < DEPTH.
- Read accepted iff if_read & if_read_ce & if_empty_n.
- Accepted write: count+1. Accepted read: count−1. Both in one cycle: count unchanged.
- Write when count = DEPTH is dropped, even if a read is accepted in the same cycle (no pass-through). Read when empty is ignored.
- Write and read pointers wrap from DEPTH−1 to 0. Non-power-of-two DEPTH is legal.
- Output stage prefetches from memory whenever it is empty or being popped and memory is non-empty.
- `if_full_n` next value: (count_next < DEPTH−GRACE_PERIOD).
- Reset: count=0, pointers=0, if_full_n=0, if_empty_n=0, if_dout=0, if_error=0. Reset mid-operation discards all contents.

## Timing
- `if_full_n` rises on the first edge after reset deasserts.
- Write accepted at edge k into an empty FIFO: `if_empty_n`=1 and `if_dout` valid after edge k+2. Same latency in both memory styles.
- Sustained throughput: 1 write and 1 read per cycle with no bubbles when occupancy ≥ 2.
- `if_full_n` falls at the same edge count reaches DEPTH−GRACE_PERIOD.
- `if_full_n` rises at the edge count drops below that value.
- After a pop, the next word appears on `if_dout` at that same edge if it is already prefetched.
- Enable low (`if_write_ce` or `if_read_ce`): that side is frozen and its request is ignored.

## Configuration
- FIFO_ERROR_CHECK_EN defined:
  - Sets `if_error` on a write attempt (if_write & if_write_ce) while count = DEPTH.
  - Sets `if_error` on a read attempt (if_read & if_read_ce) while if_empty_n = 0.
  - `if_error` stays set until reset.
- FIFO_ERROR_CHECK_EN undefined: `if_error` tied to 0, no check logic.

## Structure
- Shared package `fifo_pkg` holds:
  - the `"block"`/`"registers"` memory-style string constants;
  - the style-select rule (DATA_WIDTH*DEPTH > THRESHOLD);
  - a clog2 helper.
- Sub-module `fifo_mem`: simple dual-port memory, one write port and one registered read port, storage style from a MEM_STYLE parameter.
- Top level holds the pointers, the counter, prefetch control and the flags.

## Test plan
- DEPTH=4, GRACE_PERIOD=2, 4 back-to-back writes 0xA..0xD:
  - `if_full_n` falls after the 2nd write edge;
  - writes 3 and 4 are accepted;
  - a 5th write (0xE) is dropped; reads return A,B,C,D.
- Empty FIFO, single write at edge k → `if_empty_n`=1 and `if_dout` valid after edge k+2, for THRESHOLD=0 (block) and THRESHOLD=1<<20 (registers).
- DEPTH=5 (non-power-of-two), 20 words through with random read/write stalls → output order exact, pointers wrap, no loss.
- Simultaneous read and write at count=1 and at count=DEPTH:
  - at count=1, count stays 1 and data order is kept;
  - at count=DEPTH, the write is dropped and count becomes DEPTH−1.
- Reset asserted with 3 words stored → next cycle if_empty_n=0, if_full_n=0, if_dout=0; if_full_n=1 one edge after reset release.
- With FIFO_ERROR_CHECK_EN defined, a read on an empty FIFO → if_error=1 and held until reset. Without the macro, the same stimulus leaves if_error=0.
